// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle for alu_rr_arbiter.
//   r0_* / r1_* : per-requester valid/ready handshake carrying operand A,
//                 operand B and a 4-bit ALU opcode.
//   rsp_*       : single shared response channel carrying the registered
//                 ALU result and the ID of the requester that issued it.
// The master modport is the side that issues operations and consumes
// responses. The slave modport is the arbiter.
interface alu_rr_arbiter_if;
    logic       r0_valid;
    logic       r0_ready;
    logic [7:0] r0_a;
    logic [7:0] r0_b;
    logic [3:0] r0_sel;
    logic       r1_valid;
    logic       r1_ready;
    logic [7:0] r1_a;
    logic [7:0] r1_b;
    logic [3:0] r1_sel;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_result;

    modport master (
        output r0_valid, r0_a, r0_b, r0_sel,
        output r1_valid, r1_a, r1_b, r1_sel,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_sel,
        input  r1_valid, r1_a, r1_b, r1_sel,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational 8-bit ALU between two requesters.
// A round-robin arbiter accepts one operation at a time, registers its
// operands, evaluates the ALU for one cycle and holds the tagged result on
// the response channel until it is consumed.
// Ports:
//   clk      : single clock, rising edge.
//   rst_n    : synchronous active-low reset.
//   bus      : alu_rr_arbiter_if.slave (request ports r0/r1, response port).
//   busy     : high whenever the controller is not idle.
//   op_count : completed response handshakes, wraps modulo 2^CNT_W.
// Also contains alu_8bit, the shared combinational ALU
// (A, B, ALU_Sel -> ALU_Result).

module alu_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_Result
);
    // Opcode decode. Division by zero yields 0 so the result is always defined.
    always_comb begin
        ALU_Result = 8'h00;
        case (ALU_Sel)
            4'b0000: ALU_Result = A + B;
            4'b0001: ALU_Result = A - B;
            4'b0010: ALU_Result = A * B;
            4'b0011: begin
                if (B == 8'h00) begin
                    ALU_Result = 8'h00;
                end else begin
                    ALU_Result = A / B;
                end
            end
            4'b0100: ALU_Result = {A[6:0], 1'b0};
            4'b0101: ALU_Result = {1'b0, A[7:1]};
            4'b0110: ALU_Result = {A[6:0], A[7]};
            4'b0111: ALU_Result = {A[0], A[7:1]};
            4'b1000: ALU_Result = A & B;
            4'b1001: ALU_Result = A | B;
            4'b1010: ALU_Result = A ^ B;
            4'b1011: ALU_Result = ~(A | B);
            4'b1100: ALU_Result = ~(A & B);
            4'b1101: ALU_Result = ~(A ^ B);
            4'b1110: ALU_Result = (A > B) ? 8'h01 : 8'h00;
            4'b1111: ALU_Result = (A == B) ? 8'h01 : 8'h00;
            default: ALU_Result = 8'h00;
        endcase
    end
endmodule

module alu_rr_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_rr_arbiter_if.slave     bus,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               last_grant_r;
    logic               id_r;
    logic [7:0]         op_a_r;
    logic [7:0]         op_b_r;
    logic [3:0]         op_sel_r;
    logic               rsp_valid_r;
    logic               rsp_id_r;
    logic [7:0]         rsp_result_r;
    logic [CNT_W-1:0]   op_count_r;
    logic               winner_s;
    logic               grant0_s;
    logic               grant1_s;
    logic               rsp_hs_s;
    logic [7:0]         alu_result_s;

    alu_8bit u_alu (
        .A          (op_a_r),
        .B          (op_b_r),
        .ALU_Sel    (op_sel_r),
        .ALU_Result (alu_result_s)
    );

    // Arbitration and next-state logic. Grants are also held off while
    // rst_n is low so no handshake can be seen during reset.
    always_comb begin
        winner_s    = 1'b0;
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        rsp_hs_s    = 1'b0;
        state_nxt_s = state_r;
        if (bus.r0_valid && bus.r1_valid) begin
            winner_s = ~last_grant_r;
        end else if (bus.r1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        grant0_s = rst_n && (state_r == IDLE) && bus.r0_valid && !winner_s;
        grant1_s = rst_n && (state_r == IDLE) && bus.r1_valid &&  winner_s;
        rsp_hs_s = (state_r == RESP) && rsp_valid_r && bus.rsp_ready;
        case (state_r)
            IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture on the request handshake, result capture after the
    // single EXEC cycle, response retirement and completion counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            op_a_r       <= 8'h00;
            op_b_r       <= 8'h00;
            op_sel_r     <= 4'h0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_result_r <= 8'h00;
            op_count_r   <= '0;
        end else begin
            if (grant0_s || grant1_s) begin
                op_a_r       <= grant1_s ? bus.r1_a   : bus.r0_a;
                op_b_r       <= grant1_s ? bus.r1_b   : bus.r0_b;
                op_sel_r     <= grant1_s ? bus.r1_sel : bus.r0_sel;
                id_r         <= grant1_s;
                last_grant_r <= grant1_s;
            end
            if (state_r == EXEC) begin
                rsp_result_r <= alu_result_s;
                rsp_id_r     <= id_r;
                rsp_valid_r  <= 1'b1;
            end else if (rsp_hs_s) begin
                rsp_valid_r  <= 1'b0;
                op_count_r   <= op_count_r + CNT_W'(1);
            end
        end
    end

    assign bus.r0_ready   = grant0_s;
    assign bus.r1_ready   = grant1_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign busy           = (state_r != IDLE);
    assign op_count       = op_count_r;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter. A second instance with a
// 2-bit counter exercises op_count wrap-around.
module tb_alu_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] op_count;
    logic        w_busy;
    logic [1:0]  w_op_count;
    int          errors = 0;
    int          checks = 0;

    alu_rr_arbiter_if bus ();
    alu_rr_arbiter_if wbus ();

    alu_rr_arbiter #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    alu_rr_arbiter #(.CNT_W(2)) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (wbus),
        .busy     (w_busy),
        .op_count (w_op_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.r0_valid = 1'b0; bus.r0_a = 8'h00; bus.r0_b = 8'h00; bus.r0_sel = 4'h0;
        bus.r1_valid = 1'b0; bus.r1_a = 8'h00; bus.r1_b = 8'h00; bus.r1_sel = 4'h0;
        bus.rsp_ready = 1'b0;
        wbus.r0_valid = 1'b0; wbus.r0_a = 8'h00; wbus.r0_b = 8'h00; wbus.r0_sel = 4'h0;
        wbus.r1_valid = 1'b0; wbus.r1_a = 8'h00; wbus.r1_b = 8'h00; wbus.r1_sel = 4'h0;
        wbus.rsp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.r0_valid = 1'b1; bus.r0_a = 8'h01; bus.r0_b = 8'h02;
        bus.r1_valid = 1'b1; bus.r1_a = 8'h03; bus.r1_b = 8'h04;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checks++;
            if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
                errors++; $display("FAIL reset_ready got %b exp 00", {bus.r0_ready, bus.r1_ready});
            end
            checks++;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL reset_valid_busy got %b%b exp 00", bus.rsp_valid, busy);
            end
            checks++;
            if (op_count !== 16'd0) begin
                errors++; $display("FAIL reset_count got %0d exp 0", op_count);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_first_grant got %b exp 10", {bus.r0_ready, bus.r1_ready});
        end
    endtask

    task automatic test_single();
        apply_reset();
        bus.r0_valid = 1'b1; bus.r0_a = 8'h0A; bus.r0_b = 8'h03; bus.r0_sel = 4'b0000;
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready got %b%b exp 10", bus.r0_ready, bus.r1_ready);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || bus.r0_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_exec got busy=%b rdy=%b v=%b exp 1,0,0", busy, bus.r0_ready, bus.rsp_valid);
        end
        tick();
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'h0D || bus.rsp_id !== 1'b0) begin
            errors++; $display("FAIL single_rsp got v=%b r=%h id=%b exp 1,0d,0", bus.rsp_valid, bus.rsp_result, bus.rsp_id);
        end
        tick();
        #1;
        checks++;
        if (op_count !== 16'd1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done got cnt=%0d v=%b busy=%b exp 1,0,0", op_count, bus.rsp_valid, busy);
        end
        checks++;
        if (bus.r0_ready !== 1'b1) begin
            errors++; $display("FAIL single_regrant got %b exp 1", bus.r0_ready);
        end
        // Dropping valid without a handshake must leave everything idle.
        bus.r0_valid = 1'b0;
        #1;
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || op_count !== 16'd1) begin
            errors++; $display("FAIL single_drop got busy=%b v=%b cnt=%0d exp 0,0,1", busy, bus.rsp_valid, op_count);
        end
    endtask

    task automatic test_contention();
        logic       g;
        logic [7:0] exp_r;
        apply_reset();
        bus.r0_valid = 1'b1; bus.r0_a = 8'h0A; bus.r0_b = 8'h03; bus.r0_sel = 4'b0001;
        bus.r1_valid = 1'b1; bus.r1_a = 8'h0A; bus.r1_b = 8'h03; bus.r1_sel = 4'b1000;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g     = (i % 2 == 1);
            exp_r = g ? 8'h02 : 8'h07;
            #1;
            checks++;
            if ({bus.r0_ready, bus.r1_ready} !== {~g, g}) begin
                errors++; $display("FAIL cont_grant%0d got %b exp %b", i, {bus.r0_ready, bus.r1_ready}, {~g, g});
            end
            tick();
            #1;
            checks++;
            if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
                errors++; $display("FAIL cont_exec_ready%0d got %b exp 00", i, {bus.r0_ready, bus.r1_ready});
            end
            tick();
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== exp_r || bus.rsp_id !== g) begin
                errors++; $display("FAIL cont_rsp%0d got v=%b r=%h id=%b exp 1,%h,%b", i, bus.rsp_valid, bus.rsp_result, bus.rsp_id, exp_r, g);
            end
            tick();
            checks++;
            if (op_count !== 16'(i + 1)) begin
                errors++; $display("FAIL cont_count%0d got %0d exp %0d", i, op_count, i + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.r1_valid = 1'b1; bus.r1_a = 8'h0A; bus.r1_b = 8'h03; bus.r1_sel = 4'b1010;
        bus.rsp_ready = 1'b0;
        #1;
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_grant got %b exp 01", {bus.r0_ready, bus.r1_ready});
        end
        tick();
        // Operands change after the handshake edge and must not be picked up.
        bus.r1_a = 8'hFF; bus.r1_b = 8'hFF; bus.r1_sel = 4'b0000;
        bus.r0_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'h09 || bus.rsp_id !== 1'b1 || op_count !== 16'd0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b r=%h id=%b cnt=%0d exp 1,09,1,0", i, bus.rsp_valid, bus.rsp_result, bus.rsp_id, op_count);
            end
            checks++;
            if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
                errors++; $display("FAIL bp_ready%0d got %b exp 00", i, {bus.r0_ready, bus.r1_ready});
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (op_count !== 16'd1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release got cnt=%0d v=%b busy=%b exp 1,0,0", op_count, bus.rsp_valid, busy);
        end
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
            errors++; $display("FAIL bp_next_grant got %b exp 10", {bus.r0_ready, bus.r1_ready});
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.r0_valid = 1'b1; bus.r0_a = 8'h0A; bus.r0_b = 8'h03; bus.r0_sel = 4'b0000;
        bus.rsp_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        bus.r1_valid = 1'b1;
        tick();
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin
            errors++; $display("FAIL mid_reset got v=%b busy=%b cnt=%0d exp 0,0,0", bus.rsp_valid, busy, op_count);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
            errors++; $display("FAIL mid_tie got %b exp 10", {bus.r0_ready, bus.r1_ready});
        end
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0 || op_count !== 16'd0) begin
                errors++; $display("FAIL mid_no_rsp%0d got v=%b cnt=%0d exp 0,0", i, bus.rsp_valid, op_count);
            end
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] res;
    } vec_t;

    task automatic test_opcodes();
        vec_t v [18];
        v[0]  = '{8'h0A, 8'h03, 4'h0, 8'h0D};
        v[1]  = '{8'h0A, 8'h03, 4'h1, 8'h07};
        v[2]  = '{8'h0A, 8'h03, 4'h2, 8'h1E};
        v[3]  = '{8'h0A, 8'h03, 4'h3, 8'h03};
        v[4]  = '{8'h0A, 8'h03, 4'h4, 8'h14};
        v[5]  = '{8'h0A, 8'h03, 4'h5, 8'h05};
        v[6]  = '{8'h81, 8'h03, 4'h6, 8'h03};
        v[7]  = '{8'h81, 8'h03, 4'h7, 8'hC0};
        v[8]  = '{8'h0A, 8'h03, 4'h8, 8'h02};
        v[9]  = '{8'h0A, 8'h03, 4'h9, 8'h0B};
        v[10] = '{8'h0A, 8'h03, 4'hA, 8'h09};
        v[11] = '{8'h0A, 8'h03, 4'hB, 8'hF4};
        v[12] = '{8'h0A, 8'h03, 4'hC, 8'hFD};
        v[13] = '{8'h0A, 8'h03, 4'hD, 8'hF6};
        v[14] = '{8'h0A, 8'h03, 4'hE, 8'h01};
        v[15] = '{8'h0A, 8'h03, 4'hF, 8'h00};
        v[16] = '{8'h81, 8'h03, 4'h4, 8'h02};
        v[17] = '{8'h81, 8'h03, 4'h5, 8'h40};
        apply_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.r0_valid = 1'b1; bus.r0_a = v[i].a; bus.r0_b = v[i].b; bus.r0_sel = v[i].sel;
            tick();
            bus.r0_valid = 1'b0;
            tick();
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== v[i].res) begin
                errors++; $display("FAIL opcode%0d sel=%h got v=%b r=%h exp 1,%h", i, v[i].sel, bus.rsp_valid, bus.rsp_result, v[i].res);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
        apply_reset();
        wbus.r0_valid = 1'b1; wbus.r0_a = 8'h05; wbus.r0_b = 8'h01; wbus.r0_sel = 4'h0;
        wbus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            tick();
            checks++;
            if (w_op_count !== exp_cnt[i]) begin
                errors++; $display("FAIL wrap%0d got %0d exp %0d", i, w_op_count, exp_cnt[i]);
            end
        end
        wbus.r0_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_opcodes();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one instance of the team's combinational 8-bit ALU (alu_8bit: A, B, ALU_Sel[3:0] -> ALU_Result[7:0]) between two requesters.
- Round-robin arbitration with valid/ready handshakes on each request port.
- Operands are registered, the result is registered, and responses go out on one shared channel tagged with the requester ID.
- Sits between two command sources, e.g. sequencers or a CPU-side port, and the ALU datapath.

Parameters:
- CNT_W, 16, width of the completed-operation counter op_count.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low. Sampled only on the rising edge of clk.
- r0_valid  input  1  requester 0 has an operation.
- r0_ready  output  1  requester 0 operation accepted this cycle.
- r0_a  input  8  requester 0 operand A.
- r0_b  input  8  requester 0 operand B.
- r0_sel  input  4  requester 0 ALU opcode (ALU_Sel encoding).
- r1_valid, r1_ready, r1_a, r1_b, r1_sel: same as r0_*, for requester 1.
- rsp_valid  output  1  response holds a valid result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that issued the operation (0 or 1).
- rsp_result  output  8  registered ALU_Result.
- busy  output  1  high whenever the state is not IDLE.
- op_count  output  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:

Reset (rst_n low at a rising edge):
- state <= IDLE; rsp_valid <= 0; rsp_result <= 0; rsp_id <= 0; op_count <= 0.
- last_grant <= 1, so requester 0 wins the first tie.
- Operand registers <= 0.
- Reset mid-operation discards the in-flight operation; no response is produced for it.

FSM states: IDLE, EXEC, RESP.

IDLE:
- Winner is the only valid requester. If both are valid, the winner is the one != last_grant.
- r0_ready = (state==IDLE) && r0_valid && winner==0, combinational; r1_ready is symmetric.
- At most one ready is high in any cycle. Both readys are 0 outside IDLE.
- On handshake (rX_valid && rX_ready at edge k):
  - Capture a/b/sel into operand registers; id <= X; last_grant <= X; state <= EXEC.
- No valid requester: stay in IDLE.

EXEC (exactly one cycle):
- ALU is driven from the operand registers.
- At edge k+1: rsp_result <= ALU_Result; rsp_id <= id; rsp_valid <= 1; state <= RESP.

RESP:
- rsp_valid, rsp_result and rsp_id are held stable until rsp_ready.
- On rsp_valid && rsp_ready at an edge: rsp_valid <= 0; op_count <= op_count + 1; state <= IDLE.
- No combinational path from rsp_ready to any rX_ready.

Timing and throughput:
- Request-handshake to rsp_valid high: 1 cycle, registered at edge k+1.
- Maximum throughput is one operation per 3 cycles with rsp_ready held high.

Boundary conditions:
- A requester dropping valid without a handshake has no effect.
- Operands are sampled only on the handshake edge.
- rsp_ready while rsp_valid=0 is ignored.
- All 16 opcodes are passed through unchanged; result semantics are those of alu_8bit.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with r0_valid=r1_valid=1 -> r0_ready=r1_ready=0, rsp_valid=0, busy=0, op_count=0. Releasing reset, both still valid -> r0 granted first.
2. Single request: r0 A=0x0A, B=0x03, sel=0000, rsp_ready=1 -> r0_ready=1 in the handshake cycle; rsp_valid=1 one edge after EXEC with rsp_result=0x0D, rsp_id=0; op_count=1; next grant possible 3 cycles after the first.
3. Contention: both valid continuously, r0 (0x0A,0x03,sel=0001), r1 (0x0A,0x03,sel=1000) -> grants alternate 0,1,0,1; responses 0x07/id0, 0x02/id1, 0x07/id0, ...; never two readys high together.
4. Backpressure: r1 (0x0A,0x03,sel=1010), rsp_ready=0 for 5 cycles -> rsp_valid=1, rsp_result=0x09, rsp_id=1 stable; r0_ready=r1_ready=0; op_count unchanged. rsp_ready=1 -> op_count+1, back to IDLE.
5. Reset mid-operation: assert rst_n=0 at the edge that would enter RESP -> rsp_valid=0, busy=0 after that edge; no response for the dropped operation; next tie grants r0.
6. Counter wrap: CNT_W=2, run 5 operations -> op_count sequence 1,2,3,0,1.
